// File: rtl/power3_rr_scheduler.sv
// power3_rr_scheduler: round-robin arbiter sharing one cube engine among requesters, with watchdog timeout
module power3_rr_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_x,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic                 o_rsp_valid,
    output logic [7:0]           o_rsp_data,
    output logic [ID_W-1:0]      o_rsp_id,
    output logic                 o_rsp_timeout,
    input  logic                 i_rsp_ready,
    output logic                 o_eng_start,
    output logic [7:0]           o_eng_x,
    input  logic [7:0]           i_eng_xPower,
    input  logic                 i_eng_finished
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;
    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d, rsp_id_q, rsp_id_d;
    logic [7:0]      eng_x_q, eng_x_d, rsp_data_q, rsp_data_d;
    logic            rsp_to_q, rsp_to_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [ID_W-1:0] grant;
    logic            any_req;
    assign any_req = |i_req_valid;
    // Scan downward so the lowest offset from the pointer is the last (winning) assignment
    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (i_req_valid[idx]) grant = ID_W'(idx);
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            rsp_id_q   <= '0;
            eng_x_q    <= '0;
            rsp_data_q <= '0;
            rsp_to_q   <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            rsp_id_q   <= rsp_id_d;
            eng_x_q    <= eng_x_d;
            rsp_data_q <= rsp_data_d;
            rsp_to_q   <= rsp_to_d;
            wd_q       <= wd_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        rsp_id_d   = rsp_id_q;
        eng_x_d    = eng_x_q;
        rsp_data_d = rsp_data_q;
        rsp_to_d   = rsp_to_q;
        wd_d       = wd_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    eng_x_d  = i_req_x[8*int'(grant) +: 8];
                    rsp_id_d = grant;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                wd_d    = '0;
                state_d = BUSY;
            end
            BUSY: begin
                if (i_eng_finished) begin
                    rsp_data_d = i_eng_xPower;
                    rsp_to_d   = 1'b0;
                    state_d    = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_d = '0;
                        rsp_to_d   = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        o_req_ready = '0;
        if (state_q == IDLE && any_req) o_req_ready[grant] = 1'b1;
        o_eng_start   = state_q == LAUNCH;
        o_rsp_valid   = state_q == RESP;
        o_rsp_data    = rsp_data_q;
        o_rsp_id      = rsp_id_q;
        o_rsp_timeout = rsp_to_q;
        o_eng_x       = eng_x_q;
    end
endmodule

// File: tb/tb_power3_rr_scheduler.sv
// tb_power3_rr_scheduler: directed stimulus with a response scoreboard and a stub cube engine
module tb_power3_rr_scheduler;
    localparam int N = 4;
    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_x = '0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [7:0]     rsp_data;
    logic [1:0]     rsp_id;
    logic           rsp_to;
    logic           rsp_ready = 1'b1;
    logic           eng_start;
    logic [7:0]     eng_x;
    logic [7:0]     eng_xp = '0;
    logic           eng_fin;
    logic [1:0]     eng_cnt = '0;
    logic           hang = 1'b0;
    int checks = 0;
    int errors = 0;
    int q_id[$];
    int q_data[$];
    int q_to[$];

    power3_rr_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(15)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(req_valid), .i_req_x(req_x), .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_id(rsp_id),
        .o_rsp_timeout(rsp_to), .i_rsp_ready(rsp_ready),
        .o_eng_start(eng_start), .o_eng_x(eng_x),
        .i_eng_xPower(eng_xp), .i_eng_finished(eng_fin)
    );

    always #5 i_clk = ~i_clk;

    // Engine stub: finished drops for two cycles after start, result ready in the third
    always @(posedge i_clk) begin
        if (i_rst) eng_cnt <= '0;
        else if (eng_start) begin
            eng_cnt <= 2'd2;
            eng_xp  <= eng_x * eng_x * eng_x;
        end else if (eng_cnt != 0) eng_cnt <= eng_cnt - 2'd1;
    end
    assign eng_fin = (eng_cnt == 0) && !hang;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input int data, input int to);
        q_id.push_back(id);
        q_data.push_back(data);
        q_to.push_back(to);
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && rsp_valid && rsp_ready) begin
            if (q_id.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
                chk("rsp_id", int'(rsp_id), q_id.pop_front());
                chk("rsp_data", int'(rsp_data), q_data.pop_front());
                chk("rsp_timeout", int'(rsp_to), q_to.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        if (!rsp_valid) chk("rsp_wait_bound", 0, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 0);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_data"}, int'(rsp_data), 0);
        chk({tag, "_rsp_id"}, int'(rsp_id), 0);
        chk({tag, "_rsp_timeout"}, int'(rsp_to), 0);
        chk({tag, "_eng_start"}, int'(eng_start), 0);
        chk({tag, "_eng_x"}, int'(eng_x), 0);
    endtask

    task automatic req(input int k, input int x, input int d, input int to, input int lat);
        int n;
        tick();
        req_valid[k] = 1'b1;
        req_x[8*k +: 8] = 8'(x);
        #1;
        chk("grant", int'(req_ready), 1 << k);
        push(k, d, to);
        tick();
        req_valid[k] = 1'b0;
        chk("eng_start", int'(eng_start), 1);
        chk("eng_x", int'(eng_x), x);
        tick();
        chk("eng_start_pulse", int'(eng_start), 0);
        wait_rsp(n);
        chk("latency", n, lat);
    endtask

    initial begin
        int n;
        int seq[5] = '{0, 1, 2, 3, 0};
        int dat[4] = '{1, 8, 125, 232};
        int ng, last, cyc, b;
        tick();
        tick();
        chk_reset("reset");
        i_rst = 1'b0;
        req(0, 3, 27, 0, 3);
        req(2, 7, 87, 0, 3);
        req(1, 255, 255, 0, 3);

        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        req_x = {8'd10, 8'd5, 8'd2, 8'd1};
        req_valid = '1;
        #1;
        ng = 0; last = 0; cyc = 0;
        while (ng < 5 && cyc < 60) begin
            if (req_ready != 0) begin
                chk("rr_grant", int'(req_ready), 1 << seq[ng]);
                push(seq[ng], dat[seq[ng]], 0);
                if (ng > 0) chk("rr_spacing", cyc - last, 6);
                last = cyc;
                ng++;
            end
            if (ng < 5) begin
                tick();
                cyc++;
            end
        end
        chk("rr_grant_count", ng, 5);
        tick();
        req_valid = '0;
        b = 0;
        while (q_id.size() != 0 && b < 40) begin
            tick();
            b++;
        end
        chk("rr_drain", q_id.size(), 0);

        tick();
        rsp_ready = 1'b0;
        req_valid[0] = 1'b1;
        req_x[7:0] = 8'd4;
        #1;
        chk("stall_grant", int'(req_ready), 1);
        push(0, 64, 0);
        tick();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        req_x[15:8] = 8'd3;
        chk("stall_eng_start", int'(eng_start), 1);
        wait_rsp(n);
        chk("stall_latency", n, 4);
        repeat (10) begin
            tick();
            chk("stall_valid", int'(rsp_valid), 1);
            chk("stall_data", int'(rsp_data), 64);
            chk("stall_id", int'(rsp_id), 0);
            chk("stall_req_ready", int'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("post_stall_grant", int'(req_ready), 2);
        push(1, 27, 0);
        tick();
        req_valid[1] = 1'b0;
        chk("post_stall_start", int'(eng_start), 1);
        wait_rsp(n);
        chk("post_stall_latency", n, 4);

        hang = 1'b1;
        req(0, 9, 0, 1, 15);
        hang = 1'b0;
        req(2, 7, 87, 0, 3);

        tick();
        req_valid[2] = 1'b1;
        req_x[23:16] = 8'd6;
        #1;
        chk("rst_busy_grant", int'(req_ready), 4);
        tick();
        req_valid[2] = 1'b0;
        tick();
        chk("rst_busy_no_rsp", int'(rsp_valid), 0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk_reset("midrst");
        repeat (8) begin
            tick();
            chk("dropped_no_rsp", int'(rsp_valid), 0);
        end
        req(3, 3, 27, 0, 3);

        tick();
        tick();
        chk("queue_empty", q_id.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
